sum_bcd_display: RTL and testbench
==================================

Name: sum_bcd_display

Overview:
- Downstream stage of the 6-bit operand adder. Consumes the adder's 7-bit unsigned sum (0..126).
- Converts the sum sequentially to three BCD digits using shift-add-3 (double dabble), one bit per clock.
- Drives three registered seven-segment digit patterns for the demo board's display.
- Uses a valid/ready handshake on both input and output sides.

Parameters:
- IN_W, 7: width of the binary sum input. Supported range 1..9.
- DIGITS, 3: number of BCD digits. Must satisfy 10^DIGITS > 2^IN_W - 1.
- BLANK_LZ, 1: 1 blanks leading-zero segments; 0 shows all digits.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_sum is valid this cycle.
- in_ready  output  1  block can accept a sum (high only in IDLE).
- in_sum  input  IN_W  unsigned sum from the adder.
- out_valid  output  1  bcd/seg hold a new completed result.
- out_ready  input  1  consumer accepts the result.
- bcd  output  4*DIGITS  packed BCD digits, units in [3:0].
- seg  output  7*DIGITS  segment patterns, units in [6:0], bit order gfedcba, active high.

Behaviour:
- Clock and reset: one clock (clk). Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, out_valid=0, bcd=0, seg=0 (all segments off), shift and scratch registers=0, bit counter=0.
- While rst_n is low, in_valid is ignored. in_ready is combinational (state==IDLE), so it reads 1 during reset.
- FSM has three states: IDLE, SHIFT and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: capture in_sum into the binary shift register, clear the BCD scratch, set count=IN_W, go to SHIFT.
- SHIFT:
  - in_ready=0; in_valid is ignored (no capture, no error).
  - Each cycle, in order:
    - every scratch digit >=5 gets +3;
    - then {scratch, bin} shifts left by 1;
    - count decrements.
  - When count goes 1 to 0 on an edge, the final shifted scratch is loaded into bcd, seg is loaded from the decoded digits, out_valid is set to 1, and state goes to DONE.
- DONE:
  - out_valid=1. bcd and seg stay stable.
  - On out_ready=1: clear out_valid, go to IDLE.
  - bcd and seg keep the last result after the handshake until the next conversion completes.
- Latency:
  - Accept edge E0.
  - Shifts occur on edges E1..E(IN_W).
  - out_valid is high from the cycle after E(IN_W). Default: 7 cycles after the accept edge.
- Throughput: one conversion per IN_W+2 cycles minimum, with out_ready held high.
- Arithmetic:
  - Scratch is 4*DIGITS bits. The add-3 happens on each 4-bit digit with no carry between digits.
  - Digit values above 9 cannot occur with legal parameters.
- Segment decode:
  - 0..9 use the standard gfedcba codes: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
  - Codes 10..15 decode to 0x00.
- Leading-zero blanking (BLANK_LZ=1): a digit shows 0x00 if it and all more-significant digits are 0. The units digit is never blanked.
- Reset mid-operation (any state): everything returns to reset values immediately. A partial conversion is discarded, and out_valid never pulses for it.
- out_ready while not in DONE: ignored.

Decomposition:
- Shared package sum_bcd_pkg holds:
  - the state enum (IDLE, SHIFT, DONE);
  - the seg7 code constants for 0..9 and SEG_BLANK=0x00;
  - the function digits_needed(IN_W), used for a parameter sanity check (elaboration error if DIGITS is too small).
- Sub-module bcd_to_seg7: a combinational 4-bit to 7-bit decoder with a blank input, instantiated DIGITS times.

Test Plan:
- Reset check: assert rst_n=0 mid-run, then release → out_valid=0, bcd=0x000, seg=0, in_ready=1.
- Zero input: in_sum=0 → after 7 cycles out_valid=1, bcd=0x000, seg={0x00,0x00,0x3F}; with BLANK_LZ=0, seg={0x3F,0x3F,0x3F}.
- Maximum sum: in_sum=126 (63+63) → bcd=0x126, seg={0x06,0x5B,0x7D}.
- Two-digit value: in_sum=99 → bcd=0x099, seg={0x00,0x6F,0x6F}. Then in_sum=100 → bcd=0x100, seg={0x06,0x3F,0x3F}.
- Backpressure and ignored inputs:
  - hold out_ready=0 for 5 cycles in DONE → bcd and seg stable, in_ready=0;
  - pulse in_valid with in_sum=5 during SHIFT → ignored, and the result is still the first sum;
  - after the handshake, in_ready=1 on the next cycle.
- Exhaustive sweep: all in_sum 0..126 back-to-back with out_ready=1 → every bcd matches the reference decimal, and each acceptance-to-out_valid gap is exactly 7 cycles.

Source files
------------

// File: rtl/sum_bcd_pkg.sv
// Shared types and constants for the sum-to-BCD seven-segment display path.
// Holds the FSM encoding, segment codes and the digit-count sanity helper.
package sum_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  // Segment codes, bit order gfedcba, active high
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Decimal digits required to show the largest unsigned value of in_w bits
  function automatic int digits_needed(input int in_w);
    int max_val;
    int d;
    max_val = (1 << in_w) - 1;
    d = 1;
    while (max_val >= 10) begin
      max_val = max_val / 10;
      d = d + 1;
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to seven-segment decoder; blank forces all segments off.
// Codes 10..15 also decode to all segments off.
module bcd_to_seg7
  import sum_bcd_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/sum_bcd_display.sv
// Sequential double-dabble conversion of the adder sum to BCD plus registered 7-seg patterns.
// One bit per clock; result held with out_valid until out_ready, input accepted only when idle.
module sum_bcd_display
  import sum_bcd_pkg::*;
#(
  parameter int IN_W     = 7,
  parameter int DIGITS   = 3,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       in_sum,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int SW = 4 * DIGITS;
  localparam int CW = $clog2(IN_W + 1);

  generate
    if (DIGITS < digits_needed(IN_W)) begin : g_bad_digits
      $error("sum_bcd_display: DIGITS too small for IN_W");
    end
  endgenerate

  state_t               state, state_next;
  logic [IN_W-1:0]      bin;
  logic [SW-1:0]        scratch;
  logic [SW-1:0]        adj;
  logic [SW+IN_W-1:0]   shifted;
  logic [CW-1:0]        count;
  logic [DIGITS-1:0]    blank;
  logic [7*DIGITS-1:0]  seg_dec;
  logic                 hi_zero;

  // Add-3 correction per digit, no carry between digits
  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
    shifted = {adj, bin} << 1;
  end

  // Decode straight from the final shifted scratch so seg loads with bcd
  always_comb begin
    hi_zero = 1'b1;
    blank   = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      hi_zero  = hi_zero && (shifted[IN_W + 4*i +: 4] == 4'd0);
      blank[i] = (BLANK_LZ != 0) && (i != 0) && hi_zero;
    end
  end

  generate
    for (genvar g = 0; g < DIGITS; g++) begin : g_dec
      bcd_to_seg7 u_dec (
        .digit (shifted[IN_W + 4*g +: 4]),
        .blank (blank[g]),
        .seg   (seg_dec[7*g +: 7])
      );
    end
  endgenerate

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = SHIFT;
      SHIFT:   if (count == CW'(1)) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin       <= '0;
      scratch   <= '0;
      count     <= '0;
      bcd       <= '0;
      seg       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            bin     <= in_sum;
            scratch <= '0;
            count   <= CW'(IN_W);
          end
        end
        SHIFT: begin
          {scratch, bin} <= shifted;
          count          <= count - CW'(1);
          if (count == CW'(1)) begin
            bcd       <= shifted[SW+IN_W-1:IN_W];
            seg       <= seg_dec;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_sum_bcd_display.sv
// Bench for sum_bcd_display: decimal reference model checked every cycle plus directed cases.
module tb_sum_bcd_display;

  localparam int IN_W = 7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [6:0]  in_sum = '0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid;
  logic [11:0] bcd;
  logic [20:0] seg;
  logic        in_ready_nb, out_valid_nb;
  logic [11:0] bcd_nb;
  logic [20:0] seg_nb;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sum_bcd_display dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum),
    .out_valid(out_valid), .out_ready(out_ready), .bcd(bcd), .seg(seg)
  );

  sum_bcd_display #(.BLANK_LZ(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_nb), .in_sum(in_sum),
    .out_valid(out_valid_nb), .out_ready(out_ready), .bcd(bcd_nb), .seg(seg_nb)
  );

  logic [6:0] lut [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  function automatic logic [11:0] ref_bcd(int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [20:0] ref_seg(int v, bit blank_lz);
    logic [6:0] sh, st;
    sh = (blank_lz && v < 100) ? 7'h00 : lut[v / 100];
    st = (blank_lz && v < 10)  ? 7'h00 : lut[(v / 10) % 10];
    return {sh, st, lut[v % 10]};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: accepted when idle, result shows IN_W cycles later, held until taken
  bit          m_pending, m_valid, m_idle;
  int          m_val, m_acc, cyc;
  logic [11:0] m_bcd;
  logic [20:0] m_seg1, m_seg0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pending = 0; m_valid = 0; cyc = 0;
      m_bcd = '0; m_seg1 = '0; m_seg0 = '0;
    end else begin
      m_idle = !m_pending && !m_valid;
      cyc++;
      if (m_valid && out_ready) m_valid = 0;
      if (m_pending && (cyc - m_acc == IN_W)) begin
        m_pending = 0;
        m_valid   = 1;
        m_bcd     = ref_bcd(m_val);
        m_seg1    = ref_seg(m_val, 1'b1);
        m_seg0    = ref_seg(m_val, 1'b0);
      end
      if (m_idle && in_valid) begin
        m_pending = 1;
        m_val     = int'(in_sum);
        m_acc     = cyc;
      end
    end
  end

  bit chk_en = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_in_ready", 32'(in_ready), 32'(!m_pending && !m_valid));
      chk("cyc_out_valid", 32'(out_valid), 32'(m_valid));
      chk("cyc_bcd", 32'(bcd), 32'(m_bcd));
      chk("cyc_seg", 32'(seg), 32'(m_seg1));
      chk("cyc_out_valid_nb", 32'(out_valid_nb), 32'(m_valid));
      chk("cyc_seg_nb", 32'(seg_nb), 32'(m_seg0));
    end
  end

  // Launch one sum and wait for the result; returns cycles from accept to out_valid
  task automatic send(input int v, input bit poke, output int gap);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    chk("wait_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_sum   = 7'(v);
    @(negedge clk);
    in_valid = 1'b0;
    gap = 0;
    while (!out_valid && gap < 30) begin
      @(negedge clk);
      gap++;
      if (poke && gap == 2) begin
        in_valid = 1'b1;
        in_sum   = 7'd5;
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  int gap;

  initial begin
    // Pin the reference model with hand-computed values
    chk("pin_bcd_126", 32'(ref_bcd(126)), 32'h126);
    chk("pin_seg_126", 32'(ref_seg(126, 1'b1)), 32'({7'h06, 7'h5B, 7'h7D}));
    chk("pin_seg_99", 32'(ref_seg(99, 1'b1)), 32'({7'h00, 7'h6F, 7'h6F}));
    chk("pin_seg_0_nb", 32'(ref_seg(0, 1'b0)), 32'({7'h3F, 7'h3F, 7'h3F}));

    repeat (2) @(negedge clk);
    chk_en = 1;
    chk("rst_in_ready_low", 32'(in_ready), 32'd1);
    #1 rst_n = 1'b1;
    @(negedge clk);

    send(0, 0, gap);
    chk("zero_gap", 32'(gap), 32'd7);
    chk("zero_bcd", 32'(bcd), 32'h000);
    chk("zero_seg", 32'(seg), 32'({7'h00, 7'h00, 7'h3F}));
    chk("zero_seg_nb", 32'(seg_nb), 32'({7'h3F, 7'h3F, 7'h3F}));
    take();

    send(126, 0, gap);
    chk("max_bcd", 32'(bcd), 32'h126);
    chk("max_seg", 32'(seg), 32'({7'h06, 7'h5B, 7'h7D}));
    take();

    send(99, 0, gap);
    chk("s99_bcd", 32'(bcd), 32'h099);
    chk("s99_seg", 32'(seg), 32'({7'h00, 7'h6F, 7'h6F}));
    take();
    send(100, 0, gap);
    chk("s100_bcd", 32'(bcd), 32'h100);
    chk("s100_seg", 32'(seg), 32'({7'h06, 7'h3F, 7'h3F}));
    take();

    // Backpressure with a stray in_valid pulse during the conversion
    send(42, 1, gap);
    chk("bp_gap", 32'(gap), 32'd7);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_bcd", 32'(bcd), 32'h042);
      chk("bp_seg", 32'(seg), 32'({7'h00, 7'h66, 7'h5B}));
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
    end
    take();
    chk("post_hs_in_ready", 32'(in_ready), 32'd1);
    chk("post_hs_bcd_held", 32'(bcd), 32'h042);

    // Reset in the middle of a conversion
    in_valid = 1'b1; in_sum = 7'd77;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_bcd", 32'(bcd), 32'h000);
    chk("mid_rst_seg", 32'(seg), 32'h0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_rst_no_valid", 32'(out_valid), 32'd0);
    end

    // Back-to-back sweep of every legal sum
    out_ready = 1'b1;
    for (int v = 0; v <= 126; v++) begin
      send(v, 0, gap);
      chk("sweep_gap", 32'(gap), 32'd7);
      chk("sweep_bcd", 32'(bcd), 32'(ref_bcd(v)));
      @(negedge clk);
    end

    // Random traffic with random backpressure
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_sum    = 7'($urandom_range(0, 126));
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
